// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS E-stage multiply/divide unit holding HI/LO
// Result is computed at the start edge and parked until the busy countdown ends.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_we_q, pend_we_d;

  logic [63:0]   prod;
  logic [31:0]   mag_a, mag_b, dvsr, quo, rem;
  logic [31:0]   res_hi, res_lo;
  logic          res_we;

  // Signed divide goes through magnitudes so the 0x80000000 / -1 case wraps cleanly.
  always_comb begin
    prod   = 64'd0;
    mag_a  = src_a;
    mag_b  = src_b;
    dvsr   = 32'd1;
    quo    = 32'd0;
    rem    = 32'd0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b1;
    case (md_op)
      2'd0: begin
        prod   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      2'd1: begin
        prod   = {32'd0, src_a} * {32'd0, src_b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      2'd2: begin
        mag_a  = src_a[31] ? (~src_a + 32'd1) : src_a;
        mag_b  = src_b[31] ? (~src_b + 32'd1) : src_b;
        dvsr   = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quo    = mag_a / dvsr;
        rem    = mag_a % dvsr;
        res_lo = (src_a[31] ^ src_b[31]) ? (~quo + 32'd1) : quo;
        res_hi = src_a[31] ? (~rem + 32'd1) : rem;
        res_we = (src_b != 32'd0);
      end
      default: begin
        dvsr   = (src_b == 32'd0) ? 32'd1 : src_b;
        res_lo = src_a / dvsr;
        res_hi = src_a % dvsr;
        res_we = (src_b != 32'd0);
      end
    endcase
  end

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d    = 1'b0;
        pend_we_d = 1'b0;
        if (pend_we_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (start) begin
      busy_d    = 1'b1;
      cnt_d     = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      pend_we_d = res_we;
    end else begin
      if (hi_we) hi_d = src_a;
      if (lo_we) lo_d = src_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign busy     = busy_q;
  assign md_stall = start | busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
